ps2_key_fifo: RTL and testbench
===============================

# ps2_key_fifo

Parametrised PS/2 keyboard receiver that replaces the single-register keycode path with decoded key events. It deserialises 11-bit PS/2 frames, folds E0/F0 prefixes into one event per key action, and buffers events in a FIFO with a valid/ready handshake. A 16-bit last-two-bytes `keycode` output remains for the seven-segment debug display. It sits between the board PS2_CLK/PS2_DATA pins and the pitch-training control logic, clocked from the 50 MHz domain.

## Interface

- `FIFO_DEPTH`, 8: event FIFO entries; power of two, 2..64.
- `FILTER_LEN`, 4: consecutive identical synchronised samples required to accept a new `ps2_clk` level.
- `TIMEOUT_CYC`, 50000: idle `clk` cycles allowed between falling edges inside a frame (1 ms at 50 MHz).

- `clk` in 1: system clock, 50 MHz.
- `rst_n` in 1: asynchronous active-low reset.
- `ps2_clk` in 1: raw PS/2 clock pin, asynchronous.
- `ps2_data` in 1: raw PS/2 data pin, asynchronous.
- `ev_valid` out 1: FIFO non-empty; head event on `ev_data`.
- `ev_ready` in 1: consumer accepts the head event when high with `ev_valid`.
- `ev_data` out 10: {ext, brk, code[7:0]}.
- `ev_count` out $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- `keycode` out 16: {previous byte, latest byte}; updated on every received byte, prefixes included.
- `overflow` out 1: one-cycle pulse when an event is dropped because the FIFO is full.
- `frame_err` out 1: one-cycle pulse on a framing, parity or timeout error.

## Operation

- Input conditioning: `ps2_clk` and `ps2_data` each pass through a 2-FF synchroniser. The filtered clock changes level only after FILTER_LEN equal samples. A falling edge of the filtered clock is a one-cycle strobe.
- Frame FSM states:
  - IDLE: on a strobe with data=0 (start bit), go to DATA with bit count 0. A strobe with data=1 stays in IDLE and raises no error.
  - DATA: 8 strobes shift data in LSB first, then go to PARITY.
  - PARITY: capture the parity bit, go to STOP.
  - STOP: on a strobe, if stop=1 and the parity check passes, emit `byte_valid` for one cycle; otherwise pulse `frame_err`. Return to IDLE in both cases.
- Timeout: a down-counter reloads to TIMEOUT_CYC on every strobe. It counts only outside IDLE. On reaching 0, the FSM returns to IDLE, the partial byte is discarded and `frame_err` pulses.
- Prefix decoder, acting on `byte_valid`:
  - 0xE0 sets `ext`.
  - 0xF0 sets `brk`.
  - Any other byte pushes {ext, brk, byte} to the FIFO, then clears both flags.
  - 0xE1 (Pause) and 0xAA/0xFA responses are treated as plain codes.
- FIFO:
  - A push when full is dropped and pulses `overflow`; the prefix flags still clear.
  - A push and a pop in the same cycle while full are both performed, so nothing is dropped.
  - A pop when empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset values:
  - Every output and internal state is 0 (`ev_valid`=0, `ev_data`=0, `keycode`=0, `ev_count`=0, pulses low).
  - The FSM is in IDLE, the filter output is 1 and the flags are clear.
  - Reset asserted mid-frame discards the partial frame and empties the FIFO.

## Timing

- Pin-to-strobe delay: 2 synchroniser cycles plus FILTER_LEN cycles plus 1 edge-detect cycle.
- `byte_valid` and `keycode` update occur in the cycle after the stop-bit strobe.
- `ev_valid` rises 1 cycle after `byte_valid`, i.e. 2 cycles after the stop-bit strobe, when the FIFO was empty.
- `ev_data` shows the head entry combinationally from FIFO storage and is stable while `ev_valid` is high and `ev_ready` is low.
- Pop occurs on a clock edge with `ev_valid`&`ev_ready`. The next entry appears in the following cycle.
- `overflow` and `frame_err` are registered one-cycle pulses.

## Configuration

- `PS2_PARITY_CHECK_EN` defined:
  - The odd-parity check (data bits plus parity bit has an odd number of 1s) is enforced.
  - A mismatch drops the byte and pulses `frame_err`. Neither `keycode` nor the prefix flags change.
- `PS2_PARITY_CHECK_EN` undefined:
  - The parity bit is captured but ignored.
  - Only the start bit, stop bit and timeout can raise `frame_err`.

## Test plan

- Make code: frame 0x1C with correct parity, `ev_ready`=1 -> one event `ev_data`=0x01C, `keycode`=0x001C, `ev_valid` high exactly 1 cycle.
- Break and extended codes: bytes F0 1C, then E0 75, then E0 F0 75 -> events 0x11C, 0x275, 0x375 in order; final `keycode`=0xF075.
- Parity error (macro defined): 0x1C with wrong parity bit -> `frame_err` pulse, no event, `keycode` unchanged. Macro undefined -> event 0x01C is produced.
- Overflow: FIFO_DEPTH=4, `ev_ready`=0, send 5 make codes 0x16,0x1E,0x26,0x25,0x2E -> `ev_count`=4, one `overflow` pulse on the 5th. Draining yields 0x016,0x01E,0x026,0x025.
- Timeout: send a start bit plus 4 data bits, then hold for TIMEOUT_CYC+1 cycles -> `frame_err` pulse, FSM in IDLE. A following full frame 0x29 -> event 0x029.
- Reset mid-frame: assert `rst_n`=0 after 6 bits with 2 events queued -> `ev_valid`=0 and `ev_count`=0 immediately. After release, the next frame 0x1C -> event 0x01C.

Source files
------------

// File: rtl/ps2_key_fifo_if.sv
// Key-event stream between ps2_key_fifo and its consumer: valid/ready handshake
// plus the FIFO occupancy.
interface ps2_key_fifo_if #(
    parameter int FIFO_DEPTH = 8
);
    logic                        ev_valid;
    logic                        ev_ready;
    logic [9:0]                  ev_data;
    logic [$clog2(FIFO_DEPTH):0] ev_count;

    modport master (output ev_valid, output ev_data, output ev_count, input ev_ready);
    modport slave  (input ev_valid, input ev_data, input ev_count, output ev_ready);
endinterface

// File: rtl/ps2_key_fifo.sv
// PS/2 keyboard receiver: frame deserialiser, E0/F0 prefix folding, event FIFO.
// Optional odd-parity enforcement with `define PS2_PARITY_CHECK_EN.
module ps2_key_fifo #(
    parameter int FIFO_DEPTH  = 8,
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ps2_clk,
    input  logic          ps2_data,
    ps2_key_fifo_if.master ev,
    output logic [15:0]   keycode,
    output logic          overflow,
    output logic          frame_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    // bit 0 = ps2_clk (idles high, so its synchroniser resets to 1), bit 1 = ps2_data
    localparam logic [1:0] SYNC_INIT = 2'b01;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]    pin_in;
    logic [1:0]    sync1_reg, sync2_reg;
    logic          filt_reg, filt_prev_reg, strobe_reg;
    logic [FW-1:0] filt_cnt_reg;
    logic          dat_s;

    state_t        state_reg, state_next;
    logic [2:0]    bit_cnt_reg, bit_cnt_next;
    logic [7:0]    shift_reg, shift_next;
    logic [TW-1:0] tmo_reg, tmo_next;
    logic          byte_valid_reg, byte_valid_next;
    logic          frame_err_next;
    logic          par_ok;

    logic [15:0]   keycode_reg;
    logic          ext_reg, brk_reg;
    logic          frame_err_reg, overflow_reg;

    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          push_req, do_push, pop, full, ev_valid;

    assign pin_in = {ps2_data, ps2_clk};
    assign dat_s  = sync2_reg[1];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync1_reg[gi] <= SYNC_INIT[gi];
                    sync2_reg[gi] <= SYNC_INIT[gi];
                end else begin
                    sync1_reg[gi] <= pin_in[gi];
                    sync2_reg[gi] <= sync1_reg[gi];
                end
            end
        end
    endgenerate

    // Glitch filter: the level flips only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_reg      <= 1'b1;
            filt_prev_reg <= 1'b1;
            filt_cnt_reg  <= '0;
            strobe_reg    <= 1'b0;
        end else begin
            filt_prev_reg <= filt_reg;
            strobe_reg    <= filt_prev_reg & ~filt_reg;
            if (sync2_reg[0] == filt_reg) begin
                filt_cnt_reg <= '0;
            end else if (filt_cnt_reg == FW'(FILTER_LEN - 1)) begin
                filt_reg     <= sync2_reg[0];
                filt_cnt_reg <= '0;
            end else begin
                filt_cnt_reg <= filt_cnt_reg + 1'b1;
            end
        end
    end

`ifdef PS2_PARITY_CHECK_EN
    logic par_reg;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            par_reg <= 1'b0;
        else if (strobe_reg && state_reg == PARITY)
            par_reg <= dat_s;
    end
    assign par_ok = ^{shift_reg, par_reg};
`else
    assign par_ok = 1'b1;
`endif

    always_comb begin
        state_next      = state_reg;
        bit_cnt_next    = bit_cnt_reg;
        shift_next      = shift_reg;
        tmo_next        = tmo_reg;
        byte_valid_next = 1'b0;
        frame_err_next  = 1'b0;
        if (strobe_reg) begin
            tmo_next = TW'(TIMEOUT_CYC);
            case (state_reg)
                IDLE: begin
                    if (!dat_s) begin
                        state_next   = DATA;
                        bit_cnt_next = 3'd0;
                    end
                end
                DATA: begin
                    shift_next   = {dat_s, shift_reg[7:1]};
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7)
                        state_next = PARITY;
                end
                PARITY: state_next = STOP;
                STOP: begin
                    state_next = IDLE;
                    if (dat_s && par_ok)
                        byte_valid_next = 1'b1;
                    else
                        frame_err_next = 1'b1;
                end
                default: state_next = IDLE;
            endcase
        end else if (state_reg != IDLE) begin
            if (tmo_reg == '0) begin
                state_next     = IDLE;
                frame_err_next = 1'b1;
            end else begin
                tmo_next = tmo_reg - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            bit_cnt_reg    <= '0;
            shift_reg      <= '0;
            tmo_reg        <= '0;
            byte_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            keycode_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            bit_cnt_reg    <= bit_cnt_next;
            shift_reg      <= shift_next;
            tmo_reg        <= tmo_next;
            byte_valid_reg <= byte_valid_next;
            frame_err_reg  <= frame_err_next;
            if (byte_valid_next)
                keycode_reg <= {keycode_reg[7:0], shift_reg};
        end
    end

    // shift_reg holds the received byte while byte_valid_reg is high (FSM is back in IDLE).
    assign push_req = byte_valid_reg && (shift_reg != 8'hE0) && (shift_reg != 8'hF0);
    assign ev_valid = (count_reg != '0);
    assign full     = (count_reg == CW'(FIFO_DEPTH));
    assign pop      = ev_valid && ev.ev_ready;
    assign do_push  = push_req && (!full || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_reg      <= 1'b0;
            brk_reg      <= 1'b0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            overflow_reg <= push_req && full && !pop;
            if (byte_valid_reg) begin
                if (shift_reg == 8'hE0) begin
                    ext_reg <= 1'b1;
                end else if (shift_reg == 8'hF0) begin
                    brk_reg <= 1'b1;
                end else begin
                    ext_reg <= 1'b0;
                    brk_reg <= 1'b0;
                end
            end
            if (do_push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr_reg] <= {ext_reg, brk_reg, shift_reg};
    end

    assign ev.ev_valid = ev_valid;
    assign ev.ev_data  = ev_valid ? mem[rd_ptr_reg] : 10'd0;
    assign ev.ev_count = count_reg;
    assign keycode     = keycode_reg;
    assign overflow    = overflow_reg;
    assign frame_err   = frame_err_reg;
endmodule

// File: tb/tb_ps2_key_fifo.sv
// Directed bench for ps2_key_fifo: bit-banged PS/2 frames, event log, pulse counters.
module tb_ps2_key_fifo;
    localparam int DEPTH = 4;
    localparam int TMO   = 300;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ps2_clk, ps2_data;
    logic [15:0] keycode;
    logic        overflow, frame_err;

    ps2_key_fifo_if #(.FIFO_DEPTH(DEPTH)) ev_if ();

    ps2_key_fifo #(.FIFO_DEPTH(DEPTH), .FILTER_LEN(4), .TIMEOUT_CYC(TMO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .ev        (ev_if),
        .keycode   (keycode),
        .overflow  (overflow),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [9:0] got [64];
    int got_n     = 0;
    int valid_cyc = 0;
    int err_n     = 0;
    int ovf_n     = 0;

    always @(negedge clk) begin
        if (ev_if.ev_valid && ev_if.ev_ready && got_n < 64) begin
            got[got_n] = ev_if.ev_data;
            got_n++;
        end
        if (ev_if.ev_valid) valid_cyc++;
        if (frame_err) err_n++;
        if (overflow) ovf_n++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("[TB] ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        wait_cyc(10);
        ps2_clk = 1'b0;
        wait_cyc(20);
        ps2_clk = 1'b1;
        wait_cyc(10);
    endtask

    task automatic send_frame(input logic [7:0] code, input logic good_par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(code[i]);
        send_bit(good_par ? ~^code : ^code);
        send_bit(1'b1);
        wait_cyc(20);
    endtask

    initial begin
        int base, err0, ovf0, vc0;
        logic [7:0]  seq2 [7];
        logic [9:0]  exp2 [3];
        logic [7:0]  seq4 [5];
        logic [9:0]  exp4 [4];
        logic [7:0]  b29;
        seq2 = '{8'hF0, 8'h1C, 8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75};
        exp2 = '{10'h11C, 10'h275, 10'h375};
        seq4 = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E};
        exp4 = '{10'h016, 10'h01E, 10'h026, 10'h025};
        b29  = 8'h29;

        rst_n = 1'b0;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        ev_if.ev_ready = 1'b0;
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(10);
        check("rst_ev_valid", 32'(ev_if.ev_valid), 0);
        check("rst_ev_count", 32'(ev_if.ev_count), 0);
        check("rst_ev_data", 32'(ev_if.ev_data), 0);
        check("rst_keycode", 32'(keycode), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_frame_err", 32'(frame_err), 0);

        // make code with consumer always ready
        ev_if.ev_ready = 1'b1;
        base = got_n; vc0 = valid_cyc; err0 = err_n;
        send_frame(8'h1C, 1'b1);
        check("make_count", 32'(got_n - base), 1);
        check("make_data", 32'(got[base]), 32'h01C);
        check("make_keycode", 32'(keycode), 32'h001C);
        check("make_valid_cycles", 32'(valid_cyc - vc0), 1);

        // break / extended folding
        base = got_n;
        for (int i = 0; i < 7; i++) send_frame(seq2[i], 1'b1);
        check("prefix_count", 32'(got_n - base), 3);
        for (int i = 0; i < 3; i++) check($sformatf("prefix_ev%0d", i), 32'(got[base + i]), 32'(exp2[i]));
        check("prefix_keycode", 32'(keycode), 32'hF075);
        check("prefix_no_err", 32'(err_n - err0), 0);

        // wrong parity bit
        base = got_n; err0 = err_n;
        send_frame(8'h1C, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
        check("par_err_pulse", 32'(err_n - err0), 1);
        check("par_no_event", 32'(got_n - base), 0);
        check("par_keycode", 32'(keycode), 32'hF075);
`else
        check("par_no_err", 32'(err_n - err0), 0);
        check("par_event_count", 32'(got_n - base), 1);
        check("par_event_data", 32'(got[base]), 32'h01C);
        check("par_keycode", 32'(keycode), 32'h751C);
`endif

        // overflow with consumer stalled
        ev_if.ev_ready = 1'b0;
        ovf0 = ovf_n;
        for (int i = 0; i < 5; i++) send_frame(seq4[i], 1'b1);
        check("ovf_count", 32'(ev_if.ev_count), 4);
        check("ovf_pulses", 32'(ovf_n - ovf0), 1);
        check("ovf_head", 32'(ev_if.ev_data), 32'h016);
        base = got_n;
        ev_if.ev_ready = 1'b1;
        wait_cyc(10);
        check("drain_count", 32'(got_n - base), 4);
        for (int i = 0; i < 4; i++) check($sformatf("drain_ev%0d", i), 32'(got[base + i]), 32'(exp4[i]));
        check("drain_empty", 32'(ev_if.ev_count), 0);

        // timeout after a partial frame
        err0 = err_n;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(b29[i]);
        ps2_data = 1'b1;
        wait_cyc(TMO + 100);
        check("tmo_err_pulse", 32'(err_n - err0), 1);
        base = got_n;
        send_frame(8'h29, 1'b1);
        check("tmo_next_count", 32'(got_n - base), 1);
        check("tmo_next_data", 32'(got[base]), 32'h029);
        check("tmo_no_extra_err", 32'(err_n - err0), 1);

        // reset in the middle of a frame with events queued
        ev_if.ev_ready = 1'b0;
        send_frame(8'h1C, 1'b1);
        send_frame(8'h32, 1'b1);
        check("rstmid_queued", 32'(ev_if.ev_count), 2);
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        rst_n = 1'b0;
        #1;
        check("rstmid_ev_valid", 32'(ev_if.ev_valid), 0);
        check("rstmid_ev_count", 32'(ev_if.ev_count), 0);
        check("rstmid_keycode", 32'(keycode), 0);
        wait_cyc(5);
        rst_n = 1'b1;
        wait_cyc(5);
        ev_if.ev_ready = 1'b1;
        base = got_n;
        send_frame(8'h1C, 1'b1);
        check("rstmid_next_count", 32'(got_n - base), 1);
        check("rstmid_next_data", 32'(got[base]), 32'h01C);
        check("rstmid_next_keycode", 32'(keycode), 32'h001C);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
